// File: rtl/nios2e_nios2_gen2_0_cpu_ocimem_arbiter.sv
// OCI debug RAM arbiter: shares one single-port RAM between the JTAG
// command path and the host debug slave, with MonDReg capture.
module nios2e_nios2_gen2_0_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_addr_load,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_acc,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] jptr;
  logic              jpend;
  logic              jpend_wr;
  logic [DATA_W-1:0] jpend_wdata;
  logic              last_jtag;
  logic              cur_jtag;
  logic              cur_wr;

  logic              strobe;
  logic              jacc_ok;
  logic              jload_ok;
  logic              jreq;
  logic              grant_jtag;
  logic              grant_host;
  logic              jwr;
  logic [ADDR_W-1:0] jaddr;
  logic [DATA_W-1:0] jwdata;

  always_comb begin
    strobe     = jtag_acc | jtag_addr_load;
    jacc_ok    = jtag_acc & monitor_ready;
    jload_ok   = jtag_addr_load & monitor_ready;
    jreq       = jpend | jacc_ok;
    // a same-cycle load steers the access to the new address
    jaddr      = jload_ok ? jtag_addr : jptr;
    jwr        = jpend ? jpend_wr : jtag_wr;
    jwdata     = jpend ? jpend_wdata : jtag_wdata;
    grant_jtag = 1'b0;
    grant_host = 1'b0;
    state_nxt  = state;
    unique case (state)
      IDLE: begin
        if (jreq && host_req) begin
          grant_jtag = ~last_jtag;
          grant_host = last_jtag;
        end else begin
          grant_jtag = jreq;
          grant_host = host_req;
        end
        if (grant_jtag || grant_host) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en        <= 1'b0;
      ram_wr        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      host_ack      <= 1'b0;
      host_rdata    <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      jptr          <= '0;
      jpend         <= 1'b0;
      jpend_wr      <= 1'b0;
      jpend_wdata   <= '0;
      last_jtag     <= 1'b0;
      cur_jtag      <= 1'b0;
      cur_wr        <= 1'b0;
    end else begin
      ram_en   <= 1'b0;
      ram_wr   <= 1'b0;
      host_ack <= 1'b0;
      if (strobe && !monitor_ready) monitor_error <= 1'b1;
      if (jload_ok) begin
        jptr          <= jtag_addr;
        monitor_error <= 1'b0;
      end
      if (jacc_ok) begin
        monitor_ready <= 1'b0;
        jpend         <= 1'b1;
        jpend_wr      <= jtag_wr;
        jpend_wdata   <= jtag_wdata;
      end
      if (grant_jtag || grant_host) begin
        ram_en    <= 1'b1;
        cur_jtag  <= grant_jtag;
        last_jtag <= grant_jtag;
        if (grant_jtag) begin
          jpend     <= 1'b0;
          ram_wr    <= jwr;
          ram_addr  <= jaddr;
          ram_wdata <= jwdata;
          cur_wr    <= jwr;
        end else begin
          ram_wr    <= host_wr;
          ram_addr  <= host_addr;
          ram_wdata <= host_wdata;
          cur_wr    <= host_wr;
        end
      end
      if (state == CAPTURE) begin
        if (cur_jtag) begin
          if (!cur_wr) MonDReg <= ram_rdata;
        end else begin
          host_ack <= 1'b1;
          if (!cur_wr) host_rdata <= ram_rdata;
        end
      end
      // JTAG path reports idle once its access has fully retired
      if (state == DONE && cur_jtag) begin
        monitor_ready <= 1'b1;
        jptr          <= jptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nios2e_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter: cycle table for JTAG/host
// access timing, plus contention, wrap, busy-error and reset sequences.
module tb_nios2e_nios2_gen2_0_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        jtag_addr_load;
  logic [7:0]  jtag_addr;
  logic        jtag_acc;
  logic        jtag_wr;
  logic [31:0] jtag_wdata;
  logic        host_req;
  logic        host_wr;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        ram_en;
  logic        ram_wr;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [256];
  logic [7:0]  en_log [$];
  logic        prev_en = 1'b0;
  logic        prev_req = 1'b0;
  logic        ack_since = 1'b0;

  always #5 clk = ~clk;

  nios2e_nios2_gen2_0_cpu_ocimem_arbiter dut (
    .clk(clk), .reset(reset),
    .jtag_addr_load(jtag_addr_load), .jtag_addr(jtag_addr),
    .jtag_acc(jtag_acc), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready),
    .monitor_error(monitor_error)
  );

  // RAM model: one-cycle read latency, preloaded on reset
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h01] <= 32'h0BADF00D;
      mem[8'h80] <= 32'h80808080;
      mem[8'hFF] <= 32'hA5A500FF;
      ram_rdata  <= '0;
    end else if (ram_en) begin
      if (ram_wr) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (!reset && ram_en) begin
      checks++;
      if (prev_en) begin
        failures++;
        $display("FAIL ram_en_overlap actual=2+ cycles required=1 addr=%h", ram_addr);
      end
      en_log.push_back(ram_addr);
    end
    prev_en = ram_en;
  end

  // host protocol watch: req must stay high until ack
  always @(posedge clk) begin
    if (!reset && prev_req && !host_req && !host_ack && !ack_since) begin
      failures++;
      $display("FAIL host_req_dropped actual=0 required=1 before ack");
    end
    prev_req  <= reset ? 1'b0 : host_req;
    ack_since <= reset ? 1'b0 :
                 host_ack ? 1'b1 :
                 (host_req && !prev_req) ? 1'b0 : ack_since;
  end

  typedef struct {
    logic        ld;
    logic [7:0]  la;
    logic        acc;
    logic        wr;
    logic [31:0] wd;
    logic        hreq;
    logic        hwr;
    logic [7:0]  ha;
    logic [31:0] hwd;
    logic        en;
    logic        ewr;
    logic [7:0]  eaddr;
    logic        rdy;
    logic        ack;
    logic [31:0] mon;
    logic [31:0] hrd;
  } vec_t;

  vec_t vt [22];

  function automatic vec_t mk(int ld, int la, int acc, int wr, int wd,
                              int hreq, int hwr, int ha, int hwd,
                              int en, int ewr, int eaddr, int rdy,
                              int ack, int mon, int hrd);
    vec_t v;
    v.ld = ld[0]; v.la = la[7:0]; v.acc = acc[0]; v.wr = wr[0];
    v.wd = wd; v.hreq = hreq[0]; v.hwr = hwr[0]; v.ha = ha[7:0];
    v.hwd = hwd; v.en = en[0]; v.ewr = ewr[0]; v.eaddr = eaddr[7:0];
    v.rdy = rdy[0]; v.ack = ack[0]; v.mon = mon; v.hrd = hrd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    jtag_addr_load = 1'b0; jtag_addr = '0; jtag_acc = 1'b0;
    jtag_wr = 1'b0; jtag_wdata = '0;
    host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic check_reset_vals(string p);
    check({p, "_ram_en"}, 32'(ram_en), 32'd0);
    check({p, "_ram_wr"}, 32'(ram_wr), 32'd0);
    check({p, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({p, "_ram_wdata"}, ram_wdata, 32'd0);
    check({p, "_host_ack"}, 32'(host_ack), 32'd0);
    check({p, "_host_rdata"}, host_rdata, 32'd0);
    check({p, "_MonDReg"}, MonDReg, 32'd0);
    check({p, "_ready"}, 32'(monitor_ready), 32'd1);
    check({p, "_error"}, 32'(monitor_error), 32'd0);
  endtask

  task automatic wait_ready(string name);
    int n = 0;
    while (!monitor_ready && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(monitor_ready), 32'd1);
  endtask

  task automatic wait_ack(string name);
    int n = 0;
    while (!host_ack && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(host_ack), 32'd1);
    host_req = 1'b0;
  endtask

  task automatic jtag_cmd(logic ld, logic [7:0] a, logic acc,
                          logic wr, logic [31:0] wd);
    jtag_addr_load = ld; jtag_addr = a; jtag_acc = acc;
    jtag_wr = wr; jtag_wdata = wd;
    tick();
    jtag_addr_load = 1'b0; jtag_acc = 1'b0;
    if (acc) wait_ready("jtag_cmd_ready");
  endtask

  task automatic contend();
    jtag_acc = 1'b1; jtag_wr = 1'b0;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 8'h80;
    tick();
    jtag_acc = 1'b0;
    wait_ack("contend_ack");
    wait_ready("contend_ready");
    tick();
  endtask

  initial begin
    logic [7:0] exp_c [9];
    bit         ok;
    bit         ack_seen;

    // ld la acc wr wd | hreq hwr ha hwd | en ewr eaddr rdy ack mon hrd
    vt[0]  = mk(1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[1]  = mk(0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 'h10, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[5]  = mk(1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[6]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 'h10, 0, 0, 0, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
    vt[10] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 'h11, 0, 0, 32'hDEADBEEF, 0);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[14] = mk(0, 0, 0, 0, 0, 1, 1, 'h05, 32'h12345678, 1, 1, 'h05, 1, 0, 0, 0);
    vt[15] = mk(0, 0, 0, 0, 0, 1, 1, 'h05, 32'h12345678, 0, 0, 0, 1, 0, 0, 0);
    vt[16] = mk(0, 0, 0, 0, 0, 1, 1, 'h05, 32'h12345678, 0, 0, 0, 1, 1, 0, 0);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[18] = mk(0, 0, 0, 0, 0, 1, 0, 'h05, 0, 1, 0, 'h05, 1, 0, 0, 0);
    vt[19] = mk(0, 0, 0, 0, 0, 1, 0, 'h05, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[20] = mk(0, 0, 0, 0, 0, 1, 0, 'h05, 0, 0, 0, 0, 1, 1, 0, 32'h12345678);
    vt[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h12345678);

    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    check_reset_vals("rst0");

    reset = 1'b0;
    for (int i = 0; i < 22; i++) begin
      jtag_addr_load = vt[i].ld; jtag_addr = vt[i].la;
      jtag_acc = vt[i].acc; jtag_wr = vt[i].wr; jtag_wdata = vt[i].wd;
      host_req = vt[i].hreq; host_wr = vt[i].hwr;
      host_addr = vt[i].ha; host_wdata = vt[i].hwd;
      tick();
      checks++;
      ok = (ram_en === vt[i].en) &&
           (!vt[i].en || (ram_wr === vt[i].ewr && ram_addr === vt[i].eaddr)) &&
           (monitor_ready === vt[i].rdy) && (host_ack === vt[i].ack) &&
           (MonDReg === vt[i].mon) && (host_rdata === vt[i].hrd) &&
           (monitor_error === 1'b0);
      if (!ok) begin
        failures++;
        $display("FAIL vec%0d actual en=%b wr=%b addr=%h rdy=%b ack=%b mon=%h hrd=%h err=%b required en=%b wr=%b addr=%h rdy=%b ack=%b mon=%h hrd=%h err=0",
                 i, ram_en, ram_wr, ram_addr, monitor_ready, host_ack,
                 MonDReg, host_rdata, monitor_error, vt[i].en, vt[i].ewr,
                 vt[i].eaddr, vt[i].rdy, vt[i].ack, vt[i].mon, vt[i].hrd);
      end
    end
    idle_inputs();
    tick();

    // contention: alternating grants, history carried across rounds
    en_log.delete();
    jtag_cmd(1'b1, 8'h20, 1'b0, 1'b0, '0);
    contend();
    contend();
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, '0);
    contend();
    contend();
    exp_c = '{8'h20, 8'h80, 8'h21, 8'h80, 8'h22, 8'h80, 8'h23, 8'h80, 8'h24};
    check("contend_count", 32'(en_log.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < en_log.size())
        check($sformatf("contend_grant%0d", i), 32'(en_log[i]), 32'(exp_c[i]));
    end
    check("contend_hrdata", host_rdata, 32'h80808080);

    // load and access in the same idle cycle
    en_log.delete();
    jtag_cmd(1'b1, 8'h30, 1'b1, 1'b0, '0);
    check("ldacc_count", 32'(en_log.size()), 32'd1);
    if (en_log.size() > 0) check("ldacc_addr", 32'(en_log[0]), 32'h30);

    // busy error: second strobe one cycle after the first
    en_log.delete();
    jtag_acc = 1'b1; jtag_wr = 1'b0;
    tick();
    jtag_acc = 1'b1;
    tick();
    jtag_acc = 1'b0;
    check("busy_err_set", 32'(monitor_error), 32'd1);
    wait_ready("busy_ready");
    tick();
    check("busy_one_access", 32'(en_log.size()), 32'd1);
    if (en_log.size() > 0) check("busy_addr", 32'(en_log[0]), 32'h31);
    check("busy_err_sticky", 32'(monitor_error), 32'd1);
    jtag_cmd(1'b1, 8'hFF, 1'b0, 1'b0, '0);
    check("busy_err_clear", 32'(monitor_error), 32'd0);

    // pointer wrap from 0xFF
    en_log.delete();
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, '0);
    check("wrap_mon_ff", MonDReg, 32'hA5A500FF);
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, '0);
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, '0);
    check("wrap_mon_01", MonDReg, 32'h0BADF00D);
    check("wrap_count", 32'(en_log.size()), 32'd3);
    if (en_log.size() == 3) begin
      check("wrap_addr0", 32'(en_log[0]), 32'hFF);
      check("wrap_addr1", 32'(en_log[1]), 32'h00);
      check("wrap_addr2", 32'(en_log[2]), 32'h01);
    end

    // reset during ACCESS of a host read
    tick();
    host_req = 1'b1; host_wr = 1'b0;
    host_addr = 8'h05; host_wdata = 32'h77777777;
    tick();
    check("rst_access_en", 32'(ram_en), 32'd1);
    check("rst_access_wdata", ram_wdata, 32'h77777777);
    reset = 1'b1;
    idle_inputs();
    tick();
    check_reset_vals("rst1");
    reset = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (host_ack) ack_seen = 1'b1;
      tick();
    end
    check("rst_no_ack", 32'(ack_seen), 32'd0);
    en_log.delete();
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, '0);
    check("rst_ptr_zero", en_log.size() > 0 ? 32'(en_log[0]) : 32'hFFFF, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
